// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Contents:
//   - segment patterns (gfedcba, active-high) for codes 0..F and blank
//   - digit-select active level and the all-off select word
package seg7_scan_mux_pkg;

  typedef logic [3:0] digit_code_t;
  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_PAT_0 = 7'h3F;
  localparam seg_pat_t SEG_PAT_1 = 7'h06;
  localparam seg_pat_t SEG_PAT_2 = 7'h5B;
  localparam seg_pat_t SEG_PAT_3 = 7'h4F;
  localparam seg_pat_t SEG_PAT_4 = 7'h66;
  localparam seg_pat_t SEG_PAT_5 = 7'h6D;
  localparam seg_pat_t SEG_PAT_6 = 7'h7D;
  localparam seg_pat_t SEG_PAT_7 = 7'h07;
  localparam seg_pat_t SEG_PAT_8 = 7'h7F;
  localparam seg_pat_t SEG_PAT_9 = 7'h6F;
  localparam seg_pat_t SEG_PAT_A = 7'h77;
  localparam seg_pat_t SEG_PAT_B = 7'h7C;
  localparam seg_pat_t SEG_PAT_C = 7'h39;
  localparam seg_pat_t SEG_PAT_D = 7'h5E;
  localparam seg_pat_t SEG_PAT_E = 7'h79;
  localparam seg_pat_t SEG_PAT_F = 7'h71;
  localparam seg_pat_t SEG_BLANK = 7'h00;

  // Digit selects are active-low on the board.
  localparam logic       SEL_ACTIVE  = 1'b0;
  localparam logic [7:0] SEL_ALL_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_mux_decode.sv
// seg7_decode: 4-bit code to 7-segment pattern, pure combinational.
// Ports:
//   code   [3:0] in   digit code
//   hex_en       in   1: codes 10..15 show A,b,C,d,E,F; 0: they show blank
//   seg    [6:0] out  segment pattern gfedcba, active-high
module seg7_decode
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'h0: seg = SEG_PAT_0;
      4'h1: seg = SEG_PAT_1;
      4'h2: seg = SEG_PAT_2;
      4'h3: seg = SEG_PAT_3;
      4'h4: seg = SEG_PAT_4;
      4'h5: seg = SEG_PAT_5;
      4'h6: seg = SEG_PAT_6;
      4'h7: seg = SEG_PAT_7;
      4'h8: seg = SEG_PAT_8;
      4'h9: seg = SEG_PAT_9;
      4'hA: seg = hex_en ? SEG_PAT_A : SEG_BLANK;
      4'hB: seg = hex_en ? SEG_PAT_B : SEG_BLANK;
      4'hC: seg = hex_en ? SEG_PAT_C : SEG_BLANK;
      4'hD: seg = hex_en ? SEG_PAT_D : SEG_BLANK;
      4'hE: seg = hex_en ? SEG_PAT_E : SEG_BLANK;
      4'hF: seg = hex_en ? SEG_PAT_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit time-multiplexed 7-segment driver.
// Scans double-buffered digit codes onto shared segment/select lines with a
// programmable slot length, dead time between slots, hex/decimal decode and
// leading-zero blanking.
// Ports:
//   CLK        in   system clock
//   RESET      in   asynchronous active-high reset
//   DIGITS     in   4*NUM_DIGITS packed codes, digit 0 = DIGITS[3:0] (leftmost)
//   DP_IN      in   decimal point per digit, 1 = lit
//   LOAD       in   1-cycle strobe, captures DIGITS/DP_IN into staging
//   LZB_EN     in   1 = blank leading zeros
//   SEG_C      out  segments gfedcba, active-high, registered
//   SEG_DP     out  decimal point, active-high, registered
//   SEG_SEL    out  digit selects, active-low, registered; digit i -> bit 7-i
//   FRAME_END  out  high during the cycle of the tick that wraps the slot index
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned SCAN_DIV   = 12500,
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned HEX_MODE   = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    LOAD,
  input  logic                    LZB_EN,
  output logic [6:0]              SEG_C,
  output logic                    SEG_DP,
  output logic [7:0]              SEG_SEL,
  output logic                    FRAME_END
);

  localparam int unsigned PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PW:0]   DEAD_LIM   = PW1'(DEAD_CYC);
  localparam logic          HEX_EN     = (HEX_MODE != 0);

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick, wrap;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pend_q, pend_d;

  // Current-slot view of the display buffer
  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_blank;
  logic       prefix_zero;
  logic [6:0] dec_seg;
  logic       dead;
  logic [2:0] sel_pos;

  // Output registers
  logic [6:0] seg_c_q, seg_c_d;
  logic       seg_dp_q, seg_dp_d;
  logic [7:0] sel_q, sel_d;

  // ---------------------------------------------------------------------------
  // Prescaler and slot index
  // ---------------------------------------------------------------------------
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    wrap    = tick && (idx_q == IDX_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  assign FRAME_END = wrap;

  // ---------------------------------------------------------------------------
  // Staging / display buffers. The display only changes on the wrapping tick,
  // so a frame never mixes old and new digits. A LOAD coinciding with the
  // wrapping tick bypasses staging and lands in the display directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    stg_dig_d  = stg_dig_q;
    stg_dp_d   = stg_dp_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;

    if (LOAD) begin
      stg_dig_d = DIGITS;
      stg_dp_d  = DP_IN;
    end

    if (wrap) begin
      if (LOAD) begin
        disp_dig_d = DIGITS;
        disp_dp_d  = DP_IN;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        disp_dig_d = stg_dig_q;
        disp_dp_d  = stg_dp_q;
        pend_d     = 1'b0;
      end
    end else if (LOAD) begin
      pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit selection and leading-zero detection
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_code = 4'(disp_dig_q >> {idx_q, 2'b00});
    cur_dp   = 1'(disp_dp_q >> idx_q);

    // Digit idx is a leading zero when it and every digit left of it are 0.
    prefix_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) <= idx_q) begin
        prefix_zero = prefix_zero && (4'(disp_dig_q >> (4 * i)) == 4'd0);
      end
    end
    cur_blank = prefix_zero && (idx_q != IDX_LAST);
  end

  seg7_decode u_decode (
    .code   (cur_code),
    .hex_en (HEX_EN),
    .seg    (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Output next-state: selects are held off for the first DEAD_CYC cycles of
  // each slot so the previous digit's segments do not ghost onto the next.
  // ---------------------------------------------------------------------------
  always_comb begin
    dead    = ({1'b0, presc_q} < DEAD_LIM);
    sel_pos = 3'd7 - 3'(idx_q);
    sel_d   = SEL_ALL_OFF;
    if (!dead) begin
      sel_d[sel_pos] = SEL_ACTIVE;
    end
    seg_c_d  = (LZB_EN && cur_blank) ? SEG_BLANK : dec_seg;
    seg_dp_d = cur_dp;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      idx_q      <= '0;
      stg_dig_q  <= '0;
      stg_dp_q   <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      pend_q     <= 1'b0;
      seg_c_q    <= SEG_BLANK;
      seg_dp_q   <= 1'b0;
      sel_q      <= SEL_ALL_OFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      stg_dig_q  <= stg_dig_d;
      stg_dp_q   <= stg_dp_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      seg_c_q    <= seg_c_d;
      seg_dp_q   <= seg_dp_d;
      sel_q      <= sel_d;
    end
  end

  assign SEG_C   = seg_c_q;
  assign SEG_DP  = seg_dp_q;
  assign SEG_SEL = sel_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with SCAN_DIV=4, DEAD_CYC=1, NUM_DIGITS=4.
// Two instances share stimulus: one with hex decode, one decimal-only.
// Timeline: k counts rising edges since reset release; sampling is on the
// falling edge after edge k. Outputs at k reflect scan state after edge k-1,
// so slot = ((k-1)/4)%4 and the dead cycle is (k-1)%4 == 0.
module tb_seg7_scan_mux;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DIGITS;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic        LZB_EN;

  logic [6:0]  seg_c,  seg_c_dec;
  logic        seg_dp, seg_dp_dec;
  logic [7:0]  sel,    sel_dec;
  logic        fe,     fe_dec;

  int n_pass = 0;
  int n_chk  = 0;
  int k      = 0;

  always #5 CLK = ~CLK;

  seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .HEX_MODE(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .DIGITS(DIGITS), .DP_IN(DP_IN), .LOAD(LOAD),
    .LZB_EN(LZB_EN), .SEG_C(seg_c), .SEG_DP(seg_dp), .SEG_SEL(sel), .FRAME_END(fe)
  );

  seg7_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .HEX_MODE(0)) u_dut_dec (
    .CLK(CLK), .RESET(RESET), .DIGITS(DIGITS), .DP_IN(DP_IN), .LOAD(LOAD),
    .LZB_EN(LZB_EN), .SEG_C(seg_c_dec), .SEG_DP(seg_dp_dec), .SEG_SEL(sel_dec),
    .FRAME_END(fe_dec)
  );

  function automatic int slot_of(input int kk);
    return ((kk - 1) / 4) % 4;
  endfunction

  function automatic logic [7:0] sel_of(input int kk);
    if (((kk - 1) % 4) == 0) return 8'hFF;
    return 8'hFF ^ (8'h80 >> slot_of(kk));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic adv();
    @(negedge CLK);
    k++;
  endtask

  // Advance to cycle 'upto', checking every cycle. pats/pats_dec hold the
  // expected segment pattern per slot (slot 0 in the low 7 bits).
  task automatic run_frame(input string tag, input int upto, input logic [27:0] pats,
                           input logic [27:0] pats_dec, input logic [3:0] dps);
    logic [27:0] p;
    logic [27:0] pd;
    logic [3:0]  d;
    while (k < upto) begin
      adv();
      p  = pats >> (7 * slot_of(k));
      pd = pats_dec >> (7 * slot_of(k));
      d  = dps >> slot_of(k);
      chk($sformatf("%s_sel_k%0d", tag, k), sel, sel_of(k));
      chk($sformatf("%s_seg_k%0d", tag, k), {1'b0, seg_c}, {1'b0, p[6:0]});
      chk($sformatf("%s_segdec_k%0d", tag, k), {1'b0, seg_c_dec}, {1'b0, pd[6:0]});
      chk($sformatf("%s_dp_k%0d", tag, k), {7'b0, seg_dp}, {7'b0, d[0]});
      chk($sformatf("%s_fe_k%0d", tag, k), {7'b0, fe}, {7'b0, ((k % 16) == 15)});
    end
  endtask

  localparam logic [27:0] ALL3F = {4{7'h3F}};
  localparam logic [27:0] ALL6F = {4{7'h6F}};
  localparam logic [27:0] PAT_4321 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] PAT_LZ5  = {7'h6D, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] PAT_LZ0  = {7'h3F, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] PAT_HEX  = {7'h71, 7'h39, 7'h7C, 7'h77};
  localparam logic [27:0] PAT_NONE = '0;

  initial begin
    RESET  = 1'b1;
    LOAD   = 1'b0;
    LZB_EN = 1'b0;
    DIGITS = 16'h0000;
    DP_IN  = 4'b0000;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_sel", sel, 8'hFF);
    chk("rst_seg", {1'b0, seg_c}, 8'h00);
    chk("rst_dp", {7'b0, seg_dp}, 8'h00);
    chk("rst_fe", {7'b0, fe}, 8'h00);
    RESET = 1'b0;
    k = 0;

    // Idle scan: zeros displayed, select rotation, FRAME_END every 16 cycles
    run_frame("idle", 34, ALL3F, ALL3F, 4'b0000);

    // Mid-frame LOAD: old value held until the wrap, then 1,2,3,4
    DIGITS = 16'h4321;
    LOAD   = 1'b1;
    run_frame("ld_mid", 35, ALL3F, ALL3F, 4'b0000);
    LOAD   = 1'b0;
    DIGITS = 16'hFFFF;
    run_frame("ld_hold", 48, ALL3F, ALL3F, 4'b0000);
    run_frame("ld_new", 64, PAT_4321, PAT_4321, 4'b0000);

    // Leading-zero blanking on 5000, then on all zeros with DP on digit 2
    LZB_EN = 1'b1;
    DIGITS = 16'h5000;
    LOAD   = 1'b1;
    run_frame("lz_ld", 65, PAT_4321, PAT_4321, 4'b0000);
    LOAD   = 1'b0;
    DIGITS = 16'hFFFF;
    run_frame("lz_old", 80, PAT_4321, PAT_4321, 4'b0000);
    run_frame("lz5_a", 81, PAT_LZ5, PAT_LZ5, 4'b0000);
    DIGITS = 16'h0000;
    DP_IN  = 4'b0100;
    LOAD   = 1'b1;
    run_frame("lz5_b", 82, PAT_LZ5, PAT_LZ5, 4'b0000);
    LOAD   = 1'b0;
    DIGITS = 16'hFFFF;
    DP_IN  = 4'b0000;
    run_frame("lz5_c", 96, PAT_LZ5, PAT_LZ5, 4'b0000);
    run_frame("lz0_a", 97, PAT_LZ0, PAT_LZ0, 4'b0100);

    // Hex codes A,B,C,F vs decimal-only instance
    DIGITS = 16'hFCBA;
    LOAD   = 1'b1;
    run_frame("lz0_b", 98, PAT_LZ0, PAT_LZ0, 4'b0100);
    LOAD   = 1'b0;
    DIGITS = 16'h0000;
    run_frame("lz0_c", 112, PAT_LZ0, PAT_LZ0, 4'b0100);
    LZB_EN = 1'b0;
    run_frame("hex", 127, PAT_HEX, PAT_NONE, 4'b0000);

    // LOAD exactly on the wrapping tick goes straight to the display
    DIGITS = 16'h9999;
    LOAD   = 1'b1;
    run_frame("wrapld_a", 128, PAT_HEX, PAT_NONE, 4'b0000);
    LOAD   = 1'b0;
    DIGITS = 16'hFFFF;
    run_frame("wrapld_b", 170, ALL6F, ALL6F, 4'b0000);

    // Asynchronous reset in the middle of slot 2
    #2 RESET = 1'b1;
    #1;
    chk("arst_sel", sel, 8'hFF);
    chk("arst_seg", {1'b0, seg_c}, 8'h00);
    chk("arst_segdec", {1'b0, seg_c_dec}, 8'h00);
    chk("arst_dp", {7'b0, seg_dp}, 8'h00);
    chk("arst_fe", {7'b0, fe}, 8'h00);
    @(negedge CLK);
    chk("arst_hold_sel", sel, 8'hFF);
    RESET = 1'b0;
    k = 0;
    run_frame("post_rst", 16, ALL3F, ALL3F, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
